lmt_update_responder: RTL and testbench
=======================================

Name: lmt_update_responder

Overview:
- Responder on the consuming side of the attestation monitor's outputs.
- Acts on the monitor's upLMT request: captures a 32-bit timestamp and writes a 3-word record (timestamp low, timestamp high, sequence number) into the LMT region through a word write port with a req/ack handshake.
- Acts on the monitor's violation reset request: stretches it into a held core reset and aborts any record write in progress.

Parameters:
LMT_BASE, 16'h0040, byte address of the record; words are written at LMT_BASE, LMT_BASE+2 and LMT_BASE+4.
RST_HOLD, 8, number of cycles core_rst stays high after viol deasserts, and after reset release; must be 1..255.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
upLMT  input  1  update request from the monitor; only its rising edge is used.
viol  input  1  combined violation reset request from the monitor; level-sensitive.
tick  input  1  timestamp increment enable.
mem_ack  input  1  write accepted; valid only while mem_req is high.
mem_req  output  1  write request.
mem_addr  output  16  write byte address.
mem_wdata  output  16  write data.
core_rst  output  1  held reset to the core.
busy  output  1  record write in progress (state is not IDLE).
done  output  1  one-cycle pulse when a record write completes.
ovf  output  1  sticky flag: an update request was dropped.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=0, mem_wdata=0, busy=0, done=0, ovf=0.
  - core_rst=1, hold counter=RST_HOLD.
  - timer=0, seq=0, pending=0, upLMT_q=0, state=IDLE.
- Timer: 32-bit, increments by 1 on each cycle with tick=1 and wraps 0xFFFFFFFF->0. Only reset clears it; viol does not.
- Edge detect:
  - A rising edge is detected in cycle N when upLMT=1 and upLMT_q=0. upLMT_q is registered every cycle.
  - The captured timestamp is the timer value in cycle N, before that cycle's increment.
- Hold counter:
  - Loaded with RST_HOLD in every cycle viol=1; otherwise decrements to 0.
  - core_rst = (counter != 0), registered. viol in cycle N gives core_rst=1 in cycle N+1.
- States: IDLE, W0, W1, W2.
  - IDLE: an edge with core_rst=0 and viol=0 captures the timestamp into ts; W0 is entered in N+1 with mem_req=1.
  - W0: addr=LMT_BASE, data=ts[15:0].
  - W1: addr=LMT_BASE+2, data=ts[31:16].
  - W2: addr=LMT_BASE+4, data=seq+1.
- Handshake:
  - A word transfers on a cycle with mem_req=1 and mem_ack=1.
  - addr and data stay stable until that transfer.
  - After a transfer the next word is presented in the following cycle; mem_req may stay high, so back-to-back transfers are allowed.
  - With mem_ack tied high, a record takes exactly 3 cycles.
- W2 transfer:
  - seq<=seq+1 (16-bit, wraps 0xFFFF->0) and done=1 in the next cycle.
  - Next state is W0 with pend_ts if pending=1 (pending cleared, no idle gap), otherwise IDLE.
- Edge while busy:
  - If pending=0: set pending=1 and capture the timestamp into pend_ts.
  - If pending=1: drop the request and set ovf=1. ovf stays set until reset.
- Edges while core_rst=1 or viol=1 are ignored: no capture, no ovf.
- viol=1 in any state:
  - Next cycle: state=IDLE, mem_req=0, pending=0, busy=0.
  - seq is unchanged and done is not pulsed; a partially written record is abandoned.
  - viol beats a same-cycle edge and a same-cycle mem_ack; a W2 ack in that cycle does not commit seq.
- Asynchronous reset mid-write: all outputs go to their reset values immediately.

Test Plan:
- Release reset with viol=0: core_rst=1 for exactly 8 cycles then 0; mem_req stays 0; ovf=0.
- tick=1, upLMT rises with timer=0x00000010, mem_ack=1:
  - writes (0x0040,0x0010), (0x0042,0x0000), (0x0044,0x0001) on 3 consecutive cycles;
  - done pulses once; busy high exactly 3 cycles.
- mem_ack delayed 2 cycles per word: mem_addr and mem_wdata stay stable while waiting; the record completes in 9 cycles with the same data.
- Second edge during W0: its record starts the cycle after the first record's W2 and writes seq 0x0002. Third edge while pending: ovf=1 and only two records are written.
- viol pulse during W1:
  - mem_req=0 next cycle; core_rst high for 8 cycles after viol falls; no write to 0x0044;
  - the next update writes seq 0x0001 if no record had completed before.
- Timer preset to 0xFFFFFFFF by running tick, edge detected in the wrap cycle: the record carries 0xFFFF/0xFFFF. After 0x10000 records (seq at 0xFFFF), the next record writes 0x0000.

Source files
------------

// File: rtl/lmt_update_responder.sv
// Writes a 3-word LMT record (timestamp low/high, sequence number) for each
// upLMT rising edge, and stretches the monitor's violation request into a held core reset.
module lmt_update_responder #(
  parameter logic [15:0] LMT_BASE   = 16'h0040,
  parameter int unsigned RST_HOLD   = 8,
  // Reset values of the timestamp timer and the record sequence number.
  parameter logic [31:0] TIMER_INIT = 32'h0000_0000,
  parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upLMT,
  input  logic        viol,
  input  logic        tick,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  // state | meaning
  // IDLE  | no record in progress
  // W0    | presenting timestamp low word at LMT_BASE
  // W1    | presenting timestamp high word at LMT_BASE+2
  // W2    | presenting sequence number at LMT_BASE+4
  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

  state_t      state, state_nx;
  logic [31:0] timer;
  logic [31:0] ts, ts_nx;
  logic [31:0] pend_ts, pend_ts_nx;
  logic [15:0] seq, seq_nx;
  logic        pending, pending_nx;
  logic        done_nx, ovf_nx;
  logic        upLMT_q;
  logic [7:0]  hold_cnt;
  logic        edge_ok;
  logic        xfer;

  assign edge_ok  = upLMT & ~upLMT_q & ~core_rst & ~viol;
  assign xfer     = mem_req & mem_ack;
  assign core_rst = (hold_cnt != 8'd0);
  assign busy     = (state != IDLE);
  assign mem_req  = busy;

  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    case (state)
      W0: begin
        mem_addr  = LMT_BASE;
        mem_wdata = ts[15:0];
      end
      W1: begin
        mem_addr  = LMT_BASE + 16'd2;
        mem_wdata = ts[31:16];
      end
      W2: begin
        mem_addr  = LMT_BASE + 16'd4;
        mem_wdata = seq + 16'd1;
      end
      default: begin
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer    <= TIMER_INIT;
      upLMT_q  <= 1'b0;
      hold_cnt <= HOLD_INIT;
    end else begin
      upLMT_q <= upLMT;
      if (tick)
        timer <= timer + 32'd1;
      if (viol)
        hold_cnt <= HOLD_INIT;
      else if (hold_cnt != 8'd0)
        hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    ts_nx      = ts;
    pend_ts_nx = pend_ts;
    pending_nx = pending;
    seq_nx     = seq;
    done_nx    = 1'b0;
    ovf_nx     = ovf;
    if (viol) begin
      state_nx   = IDLE;
      pending_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_ok) begin
            ts_nx    = timer;
            state_nx = W0;
          end
        end
        W0: if (xfer) state_nx = W1;
        W1: if (xfer) state_nx = W2;
        W2: begin
          if (xfer) begin
            seq_nx  = seq + 16'd1;
            done_nx = 1'b1;
            if (pending) begin
              ts_nx      = pend_ts;
              pending_nx = 1'b0;
              state_nx   = W0;
            end else if (edge_ok) begin
              // an edge landing on the final ack chains straight into the next record
              ts_nx    = timer;
              state_nx = W0;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
      if (busy && edge_ok && !(state == W2 && xfer && !pending)) begin
        if (!pending) begin
          pending_nx = 1'b1;
          pend_ts_nx = timer;
        end else begin
          ovf_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ts      <= 32'h0000_0000;
      pend_ts <= 32'h0000_0000;
      pending <= 1'b0;
      seq     <= SEQ_INIT;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      ts      <= ts_nx;
      pend_ts <= pend_ts_nx;
      pending <= pending_nx;
      seq     <= seq_nx;
      done    <= done_nx;
      ovf     <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_lmt_update_responder.sv
// Scoreboard bench for lmt_update_responder: expected record words are queued when an
// update edge is driven and matched against each accepted memory write.
module tb_lmt_update_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        upLMT = 1'b0, viol = 1'b0, tick = 1'b0, mem_ack = 1'b0;
  logic        mem_req, core_rst, busy, done, ovf;
  logic [15:0] mem_addr, mem_wdata;

  logic        w_upLMT = 1'b0, w_viol = 1'b0, w_tick = 1'b1;
  logic        w_ack, w_req, w_core_rst, w_busy, w_done, w_ovf;
  logic [15:0] w_addr, w_wdata;
  assign w_ack = w_req;

  localparam logic [31:0] W_TIMER_INIT = 32'hFFFF_FFC0;

  lmt_update_responder u_dut (
    .clk(clk), .reset(reset), .upLMT(upLMT), .viol(viol), .tick(tick),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .ovf(ovf)
  );

  lmt_update_responder #(.TIMER_INIT(W_TIMER_INIT), .SEQ_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .reset(reset), .upLMT(w_upLMT), .viol(w_viol), .tick(w_tick),
    .mem_ack(w_ack), .mem_req(w_req), .mem_addr(w_addr), .mem_wdata(w_wdata),
    .core_rst(w_core_rst), .busy(w_busy), .done(w_done), .ovf(w_ovf)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t q[$];
  wr_t wq[$];
  logic [15:0] sb_seq = 16'h0000;

  task automatic push_rec(input logic [31:0] t);
    q.push_back({16'h0040, t[15:0]});
    q.push_back({16'h0042, t[31:16]});
    sb_seq = sb_seq + 16'd1;
    q.push_back({16'h0044, sb_seq});
  endtask

  logic [31:0] m_timer;
  logic [31:0] w_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_timer <= 32'h0;
      w_m     <= W_TIMER_INIT;
    end else begin
      if (tick) m_timer <= m_timer + 32'd1;
      if (w_tick) w_m <= w_m + 32'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(output logic [31:0] t);
    upLMT = 1'b1;
    t = m_timer;
    cyc();
    upLMT = 1'b0;
  endtask

  int ack_dly = 0;
  int wcnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (!mem_req) begin
      wcnt = 0;
      mem_ack = 1'b0;
    end else begin
      mem_ack = (wcnt == ack_dly);
      wcnt = (wcnt == ack_dly) ? 0 : wcnt + 1;
    end
  end

  int done_cnt = 0;
  int busy_cnt = 0;
  logic hold_v = 1'b0;
  logic [15:0] h_a, h_d;
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (mem_req && hold_v) begin
      chk("stable_addr", mem_addr, h_a);
      chk("stable_data", mem_wdata, h_d);
    end
    hold_v = mem_req && !mem_ack && !viol;
    h_a = mem_addr;
    h_d = mem_wdata;
    if (mem_req && mem_ack && !viol) begin
      if (q.size() == 0) chk("sb_underflow", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (w_req && w_ack) begin
      if (wq.size() == 0) chk("wrap_underflow", wq.size(), 1);
      else begin
        e = wq.pop_front();
        chk("wrap_addr", w_addr, e.a);
        chk("wrap_data", w_wdata, e.d);
      end
    end
  end

  logic wrap_fin = 1'b0;
  initial begin : wrap_seq
    int n;
    logic [31:0] t;
    @(negedge reset);
    n = 0;
    while (w_m != 32'hFFFF_FFFF && n < 200) begin
      cyc();
      n++;
    end
    w_upLMT = 1'b1;
    wq.push_back({16'h0040, 16'hFFFF});
    wq.push_back({16'h0042, 16'hFFFF});
    wq.push_back({16'h0044, 16'h0000});
    cyc();
    w_upLMT = 1'b0;
    repeat (4) cyc();
    t = w_m;
    w_upLMT = 1'b1;
    wq.push_back({16'h0040, t[15:0]});
    wq.push_back({16'h0042, t[31:16]});
    wq.push_back({16'h0044, 16'h0001});
    cyc();
    w_upLMT = 1'b0;
    repeat (6) cyc();
    wrap_fin = 1'b1;
  end

  initial begin : main
    logic [31:0] t1, t2, t3;
    int n;
    #1 reset = 1'b1;
    #2;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    n = 0;
    @(negedge clk);
    while (core_rst && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rst_hold_cycles", n, 8);
    chk("post_rst_ovf", ovf, 0);
    chk("post_rst_req", mem_req, 0);

    // single record, ack tied high, timestamp 0x10
    cyc();
    tick = 1'b1;
    n = 0;
    while (m_timer != 32'h10 && n < 100) begin
      cyc();
      n++;
    end
    busy_cnt = 0;
    done_cnt = 0;
    pulse(t1);
    push_rec(32'h0000_0010);
    repeat (8) cyc();
    chk("rec1_busy_cycles", busy_cnt, 3);
    chk("rec1_done", done_cnt, 1);
    chk("rec1_sb_empty", q.size(), 0);

    // ack delayed two cycles per word
    ack_dly = 2;
    busy_cnt = 0;
    done_cnt = 0;
    pulse(t1);
    push_rec(t1);
    repeat (14) cyc();
    chk("slow_busy_cycles", busy_cnt, 9);
    chk("slow_done", done_cnt, 1);
    chk("slow_sb_empty", q.size(), 0);

    // second edge queues behind the first, third overflows
    ack_dly = 1;
    chk("ovf_before_chain", ovf, 0);
    busy_cnt = 0;
    done_cnt = 0;
    pulse(t1);
    push_rec(t1);
    cyc();
    pulse(t2);
    push_rec(t2);
    cyc();
    pulse(t3);
    repeat (8) cyc();
    @(negedge clk);
    #1;
    chk("chain_busy_cycles", busy_cnt, 12);
    chk("chain_tail_busy", busy, 0);
    chk("chain_done", done_cnt, 2);
    chk("chain_ovf", ovf, 1);
    chk("chain_sb_empty", q.size(), 0);

    // violation during W1 abandons the record
    ack_dly = 0;
    cyc();
    busy_cnt = 0;
    done_cnt = 0;
    pulse(t1);
    q.push_back({16'h0040, t1[15:0]});
    cyc();
    viol = 1'b1;
    @(negedge clk);
    #1;
    chk("viol_w1_addr", mem_addr, 16'h0042);
    cyc();
    viol = 1'b0;
    @(negedge clk);
    #1;
    chk("viol_req_drop", mem_req, 0);
    chk("viol_busy_drop", busy, 0);
    n = 0;
    while (core_rst && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("viol_hold_cycles", n, 8);
    chk("viol_no_done", done_cnt, 0);
    chk("viol_sb_empty", q.size(), 0);

    // edge while the core reset is held is ignored
    cyc();
    viol = 1'b1;
    cyc();
    viol = 1'b0;
    pulse(t1);
    @(negedge clk);
    #1;
    chk("hold_edge_busy", busy, 0);
    n = 0;
    while (core_rst && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("hold_release", core_rst, 0);
    chk("hold_edge_idle", busy, 0);

    // record after the abort reuses the uncommitted sequence number
    cyc();
    done_cnt = 0;
    pulse(t1);
    push_rec(t1);
    repeat (6) cyc();
    chk("after_viol_done", done_cnt, 1);
    chk("after_viol_sb_empty", q.size(), 0);

    n = 0;
    while (!wrap_fin && n < 500) begin
      cyc();
      n++;
    end
    chk("wrap_finished", wrap_fin, 1);
    chk("wrap_sb_empty", wq.size(), 0);

    // asynchronous reset in the middle of a slow write
    ack_dly = 2;
    pulse(t1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_wdata", mem_wdata, 0);
    chk("async_rst_core", core_rst, 1);
    chk("async_rst_ovf", ovf, 0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("end_sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
